// File: rtl/axis_rx_pkt_fifo.sv
// ============================================================================
// axis_rx_pkt_fifo : store-and-forward AXI-Stream RX packet FIFO that releases
//   only complete, error-free packets. Define AXIS_RX_PKT_FIFO_STATS_EN for counters.
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module axis_rx_pkt_fifo #(
    parameter int DEPTH  = 512,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_tvalid,
    input  logic [511:0]  s_tdata,
    input  logic [63:0]   s_tkeep,
    input  logic          s_tlast,
    input  logic          s_tuser_err,
    output logic          s_tready,
    output logic          m_tvalid,
    output logic [511:0]  m_tdata,
    output logic [63:0]   m_tkeep,
    output logic          m_tlast,
    output logic          m_tuser_err,
    input  logic          m_tready,
`ifdef AXIS_RX_PKT_FIFO_STATS_EN
    output logic [31:0]   pkt_cnt,
    output logic [31:0]   drop_err_cnt,
    output logic [31:0]   drop_ovf_cnt,
`endif
    output logic          drop_err,
    output logic          drop_ovf
);

    localparam int              c_ENTRY_W   = 1 + 64 + 512;
    localparam logic [ADDR_W:0] c_PTR_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } state_t;

    state_t                 state_q;
    logic [ADDR_W:0]        wr_q;
    logic [ADDR_W:0]        cm_q;
    logic [ADDR_W:0]        rd_q;
    logic                   err_seen_q;
    logic [c_ENTRY_W-1:0]   mem_q [DEPTH];

    logic                   full;
    logic                   readable;
    logic                   load;
    logic                   wr_en;
    logic [c_ENTRY_W-1:0]   rd_entry;

    assign s_tready    = 1'b1;
    assign m_tuser_err = 1'b0;

    assign full     = (wr_q - rd_q) == c_PTR_DEPTH;
    assign readable = rd_q != cm_q;
    assign load     = readable && (!m_tvalid || m_tready);
    assign wr_en    = (state_q == ST_ACCEPT) && s_tvalid && !full;
    assign rd_entry = mem_q[rd_q[ADDR_W-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_q[ADDR_W-1:0]] <= {s_tlast, s_tkeep, s_tdata};
        end
    end

    // Write side: beats land speculatively past cm_q; a drop simply rewinds wr_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ACCEPT;
            wr_q         <= '0;
            cm_q         <= '0;
            err_seen_q   <= 1'b0;
            drop_err     <= 1'b0;
            drop_ovf     <= 1'b0;
`ifdef AXIS_RX_PKT_FIFO_STATS_EN
            pkt_cnt      <= '0;
            drop_err_cnt <= '0;
            drop_ovf_cnt <= '0;
`endif
        end else begin
            drop_err <= 1'b0;
            drop_ovf <= 1'b0;
`ifdef AXIS_RX_PKT_FIFO_STATS_EN
            if (drop_err) drop_err_cnt <= drop_err_cnt + 32'd1;
            if (drop_ovf) drop_ovf_cnt <= drop_ovf_cnt + 32'd1;
`endif
            case (state_q)
                ST_ACCEPT: begin
                    if (s_tvalid) begin
                        if (full) begin
                            wr_q       <= cm_q;
                            err_seen_q <= 1'b0;
                            drop_ovf   <= 1'b1;
                            if (!s_tlast) state_q <= ST_DROP;
                        end else if (s_tlast) begin
                            err_seen_q <= 1'b0;
                            if (err_seen_q || s_tuser_err) begin
                                wr_q     <= cm_q;
                                drop_err <= 1'b1;
                            end else begin
                                wr_q <= wr_q + 1'b1;
                                cm_q <= wr_q + 1'b1;
`ifdef AXIS_RX_PKT_FIFO_STATS_EN
                                pkt_cnt <= pkt_cnt + 32'd1;
`endif
                            end
                        end else begin
                            wr_q       <= wr_q + 1'b1;
                            err_seen_q <= err_seen_q | s_tuser_err;
                        end
                    end
                end
                ST_DROP: begin
                    if (s_tvalid && s_tlast) state_q <= ST_ACCEPT;
                end
                default: state_q <= ST_ACCEPT;
            endcase
        end
    end

    // One-entry output register; only committed entries (before cm_q) are read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q     <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
        end else if (load) begin
            rd_q     <= rd_q + 1'b1;
            m_tvalid <= 1'b1;
            {m_tlast, m_tkeep, m_tdata} <= rd_entry;
        end else if (m_tvalid && m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_rx_pkt_fifo.sv
// ============================================================================
// tb_axis_rx_pkt_fifo : randomized packet stimulus against a queue-based model
//   of which packets must emerge and which must be dropped (DEPTH = 8).
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_axis_rx_pkt_fifo;

    localparam int c_DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_tvalid = 1'b0;
    logic [511:0]  s_tdata = '0;
    logic [63:0]   s_tkeep = '0;
    logic          s_tlast = 1'b0;
    logic          s_tuser_err = 1'b0;
    logic          s_tready;
    logic          m_tvalid;
    logic [511:0]  m_tdata;
    logic [63:0]   m_tkeep;
    logic          m_tlast;
    logic          m_tuser_err;
    logic          m_tready = 1'b1;
    logic          drop_err;
    logic          drop_ovf;
`ifdef AXIS_RX_PKT_FIFO_STATS_EN
    logic [31:0]   pkt_cnt;
    logic [31:0]   drop_err_cnt;
    logic [31:0]   drop_ovf_cnt;
`endif

    axis_rx_pkt_fifo #(.DEPTH(c_DEPTH)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tvalid    (s_tvalid),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .s_tuser_err (s_tuser_err),
        .s_tready    (s_tready),
        .m_tvalid    (m_tvalid),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tlast     (m_tlast),
        .m_tuser_err (m_tuser_err),
        .m_tready    (m_tready),
`ifdef AXIS_RX_PKT_FIFO_STATS_EN
        .pkt_cnt      (pkt_cnt),
        .drop_err_cnt (drop_err_cnt),
        .drop_ovf_cnt (drop_ovf_cnt),
`endif
        .drop_err    (drop_err),
        .drop_ovf    (drop_ovf)
    );

    always #5 clk = ~clk;

    int            n_checks = 0;
    int            n_pass   = 0;
    int            cyc      = 0;
    int            rmode    = 0;   // 0 ready, 1 toggle, 2 random, 3 stalled
    logic [576:0]  exp_q [$];
    int            err_exp = 0, ovf_exp = 0;
    int            err_pulses = 0, ovf_pulses = 0;
    int            good_n = 0, err_n = 0, ovf_n = 0;
    int            lat_id = 0, lat_seen = 0, tlast_cyc = 0;
    logic          hold_armed = 1'b0;
    logic [576:0]  held = '0;

    task automatic check_eq(input string tag, input logic [576:0] obs, input logic [576:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic sample();
        logic [576:0] cur;
        cur = {m_tlast, m_tkeep, m_tdata};
        if (drop_err) err_pulses++;
        if (drop_ovf) ovf_pulses++;
        if (hold_armed && m_tvalid) check_eq("hold_stable", cur, held);
        hold_armed = m_tvalid && !m_tready;
        held       = cur;
        if (lat_id != lat_seen && m_tvalid) begin
            check_eq("latency", 577'(cyc - tlast_cyc), 577'(2));
            lat_seen = lat_id;
        end
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) check_eq("extra_beat", 577'(m_tvalid), '0);
            else check_eq("beat", cur, exp_q.pop_front());
        end
    endtask

    // One clock: sample outputs mid-cycle, then advance past the edge and update ready.
    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        cyc++;
        #1;
        case (rmode)
            0: m_tready = 1'b1;
            1: m_tready = ~m_tready;
            2: m_tready = 1'($urandom_range(0, 1));
            default: m_tready = 1'b0;
        endcase
    endtask

    task automatic send_pkt(input int len, input int err_at, input bit gaps);
        logic [576:0] pkt [$];
        int n = 0;
        while (len <= c_DEPTH && exp_q.size() + len > c_DEPTH && n < 1000) begin
            tick();
            n++;
        end
        if (n >= 1000) check_eq("room_timeout", 577'(exp_q.size()), 577'(c_DEPTH - len));
        for (int i = 0; i < len; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                s_tvalid = 1'b0;
                tick();
            end
            s_tvalid    = 1'b1;
            s_tdata     = rnd512();
            s_tkeep     = {$urandom, $urandom};
            s_tlast     = (i == len - 1);
            s_tuser_err = (i + 1 == err_at);
            pkt.push_back({s_tlast, s_tkeep, s_tdata});
            if (s_tlast) tlast_cyc = cyc;
            tick();
        end
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        s_tuser_err = 1'b0;
        if (len > c_DEPTH) begin
            ovf_exp++;
            ovf_n++;
        end else if (err_at != 0) begin
            err_exp++;
            err_n++;
        end else begin
            foreach (pkt[i]) exp_q.push_back(pkt[i]);
            good_n++;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            tick();
            n++;
        end
        check_eq("drain_empty", 577'(exp_q.size()), '0);
        for (int i = 0; i < 4; i++) tick();
    endtask

    task automatic check_reset_outputs();
        check_eq("rst_m_tvalid", 577'(m_tvalid), '0);
        check_eq("rst_m_tdata", 577'(m_tdata), '0);
        check_eq("rst_m_tkeep", 577'(m_tkeep), '0);
        check_eq("rst_m_tlast", 577'(m_tlast), '0);
        check_eq("rst_m_tuser_err", 577'(m_tuser_err), '0);
        check_eq("rst_s_tready", 577'(s_tready), 577'(1));
        check_eq("rst_drop_err", 577'(drop_err), '0);
        check_eq("rst_drop_ovf", 577'(drop_ovf), '0);
    endtask

    initial begin
        int e0, o0, len, err_at;
        // Power-on reset
        repeat (3) tick();
        check_reset_outputs();
        rst_n = 1'b1;
        tick();

        // 3-beat good packet with latency measurement
        lat_id++;
        send_pkt(3, 0, 1'b0);
        drain();

        // errored 4-beat packet, then a good 2-beat packet
        e0 = err_pulses;
        o0 = ovf_pulses;
        send_pkt(4, 4, 1'b0);
        send_pkt(2, 0, 1'b0);
        drain();
        check_eq("err_pulse_once", 577'(err_pulses - e0), 577'(1));
        check_eq("err_no_ovf", 577'(ovf_pulses - o0), '0);

        // overflow: 10 beats into 8 entries while stalled, then a good packet
        rmode = 3;
        tick();
        e0 = err_pulses;
        o0 = ovf_pulses;
        send_pkt(10, 0, 1'b0);
        send_pkt(2, 0, 1'b0);
        repeat (6) tick();
        check_eq("ovf_pulse_once", 577'(ovf_pulses - o0), 577'(1));
        check_eq("ovf_no_err", 577'(err_pulses - e0), '0);
        rmode = 0;
        drain();

        // toggling backpressure over a 6-beat packet
        rmode = 1;
        send_pkt(6, 0, 1'b0);
        drain();
        rmode = 0;
        tick();

        // reset asserted during beat 2 of a 5-beat packet
        s_tvalid = 1'b1; s_tdata = rnd512(); s_tkeep = '1; s_tlast = 1'b0;
        tick();
        s_tdata = rnd512();
        #2;
        rst_n = 1'b0;
        s_tvalid = 1'b0;
        exp_q.delete();
        good_n = 0; err_n = 0; ovf_n = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_reset_outputs();
        end
        rst_n = 1'b1;
        tick();
        send_pkt(1, 0, 1'b0);
        drain();

        // 5 good, 2 errored, 1 overflowing packet
        for (int i = 0; i < 5; i++) send_pkt($urandom_range(1, 4), 0, 1'b0);
        send_pkt(3, 2, 1'b0);
        send_pkt(5, 1, 1'b1);
        send_pkt(12, 0, 1'b0);
        drain();

        // randomized traffic under random backpressure
        rmode = 2;
        for (int p = 0; p < 40; p++) begin
            len    = $urandom_range(1, 11);
            err_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, len) : 0;
            send_pkt(len, err_at, 1'b1);
        end
        drain();
        rmode = 0;
        repeat (4) tick();

        check_eq("total_drop_err", 577'(err_pulses), 577'(err_exp));
        check_eq("total_drop_ovf", 577'(ovf_pulses), 577'(ovf_exp));
`ifdef AXIS_RX_PKT_FIFO_STATS_EN
        check_eq("pkt_cnt", 577'(pkt_cnt), 577'(good_n));
        check_eq("drop_err_cnt", 577'(drop_err_cnt), 577'(err_n));
        check_eq("drop_ovf_cnt", 577'(drop_ovf_cnt), 577'(ovf_n));
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
